tennis_set_match_scorer: RTL and testbench
==========================================

Name: tennis_set_match_scorer

Overview:
- Downstream of tennis_score_fsm.
- Consumes its one-cycle p1_game_win/p2_game_win pulses and accumulates games into sets and sets into a match.
- At 6-6 in games it runs a tiebreak, scored directly from the raw point pulses.
- Drives tiebreak_active so the top level can gate point pulses away from the game FSM during a tiebreak.

Parameters:
- GAMES_PER_SET, 6, games needed to take a set (2-game lead required; tiebreak at GAMES_PER_SET all).
- TB_POINTS, 7, tiebreak points needed (2-point lead required).
- SETS_TO_WIN, 2, sets needed to win the match (best of 3).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p1_game_win  in  1  one-cycle pulse from the game FSM.
- p2_game_win  in  1  one-cycle pulse from the game FSM.
- p1_point  in  1  one-cycle point pulse (used only in tiebreak).
- p2_point  in  1  one-cycle point pulse (used only in tiebreak).
- new_match  in  1  synchronous clear of all scores.
- p1_games  out  3  games in the current set.
- p2_games  out  3  games in the current set.
- p1_tb_pts  out  4  tiebreak points.
- p2_tb_pts  out  4  tiebreak points.
- p1_sets  out  2  sets won.
- p2_sets  out  2  sets won.
- tiebreak_active  out  1  high while in S_TIEBREAK.
- p1_set_win  out  1  one-cycle pulse.
- p2_set_win  out  1  one-cycle pulse.
- p1_match_win  out  1  level, held until reset or new_match.
- p2_match_win  out  1  level, held until reset or new_match.
- protocol_err  out  1  one-cycle pulse.

Behaviour:
- Reset (async, rst_n=0): all counters 0, state S_GAMES, all pulses and levels 0. Applies mid-game, mid-tiebreak or in S_MATCH_DONE alike.
- All outputs are registered. An event sampled at edge N is visible after edge N (one-cycle latency). Set/match pulses are high for exactly one cycle.
- States: S_GAMES, S_TIEBREAK, S_MATCH_DONE.
- S_GAMES, inputs:
  - Only game_win inputs are used; point inputs are ignored.
  - pX_game_win increments pX_games.
- S_GAMES, resulting games:
  - Post-increment pX_games >= GAMES_PER_SET and lead >= 2: set won by X. Clear both games, increment pX_sets, pulse pX_set_win.
  - Games reach GAMES_PER_SET-GAMES_PER_SET (6-6): go to S_TIEBREAK, tiebreak_active=1, tb points cleared.
  - 6-5 stays in S_GAMES; 7-5 is a set.
- S_TIEBREAK, inputs:
  - game_win inputs are ignored; pX_point increments pX_tb_pts.
- S_TIEBREAK, resulting points:
  - pX_tb_pts >= TB_POINTS with lead >= 2: set won by X. Games and tb points clear to 0, pX_sets++, pX_set_win pulse, return to S_GAMES.
  - Width bound: when a point makes the scores equal and >= TB_POINTS-1, both renormalise to TB_POINTS-1 (e.g. 7-6 then the trailer scores -> 6-6, not 7-7). Counters therefore never exceed TB_POINTS.
- Match: the set win that makes pX_sets == SETS_TO_WIN also sets pX_match_win=1 in the same edge (set_win pulses too) and enters S_MATCH_DONE.
- S_MATCH_DONE: all event inputs ignored, counters frozen except games/tb, which were cleared at the set win.
- Simultaneous events:
  - Both game_win in S_GAMES, or both point in S_TIEBREAK: both ignored, protocol_err pulses, no counter change.
  - Inputs irrelevant to the current state never raise protocol_err.
- new_match=1: same effect as reset at the next edge, with priority over any coincident event.
- Arithmetic: unsigned. The lead check uses a one-bit-wider signed difference. Counters never wrap, by the rules above.

Decomposition:
- tennis_pkg holds:
  - set_state_t enum {S_GAMES, S_TIEBREAK, S_MATCH_DONE}.
  - Default constants GAMES_PER_SET_D=6, TB_POINTS_D=7, SETS_TO_WIN_D=2.
  - Width localparams (GAME_W=3, TB_W=4, SET_W=2).
- One natural sub-module: tennis_race_counter.
  - Parameterised pair counter with increment inputs, target, win-by-2 detect, and optional renormalise-at-target-1.
  - Instantiated twice: games (renormalise off) and tiebreak points (renormalise on).

Test Plan:
- Reset then 6 p1_game_win pulses -> p1_games 1..5, then on the 6th: p1_set_win pulse, p1_sets=1, games 0-0, no tiebreak.
- Games 5-5, then p1, p2, p2, p2 wins:
  - 6-5 stays in S_GAMES.
  - 6-6 gives tiebreak_active=1.
  - In tiebreak, p2_game_win is ignored and games stay 6-6.
- In tiebreak, points to 6-6, then p1, p2, p1, p1 -> 7-6, renormalised 6-6, 7-6, 8-6. On the 8-6 point: p1_set_win, p1_sets++, tiebreak_active=0, games 0-0.
- p2 wins two sets (6-0, 6-0) -> second set_win pulse coincides with p2_match_win=1. Further game_win/point pulses are ignored; new_match returns all outputs to 0.
- Same-cycle p1_game_win & p2_game_win at 3-2 -> protocol_err pulse, games remain 3-2. Same check in tiebreak with both point pulses.
- rst_n asserted asynchronously mid-tiebreak at 5-4 (between clock edges) -> all outputs 0 immediately, state S_GAMES after release.

Source files
------------

// File: rtl/tennis_pkg.sv
// Shared types and sizing for the set/match scoring slice.
package tennis_pkg;
  typedef enum logic [1:0] {S_GAMES, S_TIEBREAK, S_MATCH_DONE} set_state_t;

  localparam int GAMES_PER_SET_D = 6;
  localparam int TB_POINTS_D     = 7;
  localparam int SETS_TO_WIN_D   = 2;

  localparam int GAME_W = 3;
  localparam int TB_W   = 4;
  localparam int SET_W  = 2;
endpackage

// File: rtl/tennis_race_counter.sv
// Two-sided race counter: first side to TARGET with a 2 lead wins.
// Optional renormalisation keeps deuce-style ties pinned at TARGET-1.
module tennis_race_counter #(
  parameter int W      = 3,
  parameter int TARGET = 6,
  parameter bit RENORM = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc_a,
  input  logic         inc_b,
  output logic [W-1:0] cnt_a,
  output logic [W-1:0] cnt_b,
  output logic         win_a,
  output logic         win_b,
  output logic         tie_at_target
);
  localparam logic signed [W:0] LEAD_P = 2;
  localparam logic signed [W:0] LEAD_N = -2;

  logic [W-1:0]      nxt_a, nxt_b;
  logic signed [W:0] diff;
  logic              pin;

  always_comb begin
    nxt_a         = cnt_a + {{(W-1){1'b0}}, inc_a};
    nxt_b         = cnt_b + {{(W-1){1'b0}}, inc_b};
    diff          = $signed({1'b0, nxt_a}) - $signed({1'b0, nxt_b});
    win_a         = inc_a && (nxt_a >= W'(TARGET)) && (diff >= LEAD_P);
    win_b         = inc_b && (nxt_b >= W'(TARGET)) && (diff <= LEAD_N);
    tie_at_target = (inc_a | inc_b) && (nxt_a == nxt_b) && (nxt_a == W'(TARGET));
    // Equal scores at or past TARGET-1 collapse back so the counters stay bounded.
    pin           = RENORM && (nxt_a == nxt_b) && (nxt_a >= W'(TARGET - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (pin) begin
      cnt_a <= W'(TARGET - 1);
      cnt_b <= W'(TARGET - 1);
    end else begin
      cnt_a <= nxt_a;
      cnt_b <= nxt_b;
    end
  end
endmodule

// File: rtl/tennis_set_match_scorer.sv
// Accumulates game wins into sets and sets into a match, running a
// point-scored tiebreak at games all.
module tennis_set_match_scorer
  import tennis_pkg::*;
#(
  parameter int GAMES_PER_SET = GAMES_PER_SET_D,
  parameter int TB_POINTS     = TB_POINTS_D,
  parameter int SETS_TO_WIN   = SETS_TO_WIN_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p1_game_win,
  input  logic              p2_game_win,
  input  logic              p1_point,
  input  logic              p2_point,
  input  logic              new_match,
  output logic [GAME_W-1:0] p1_games,
  output logic [GAME_W-1:0] p2_games,
  output logic [TB_W-1:0]   p1_tb_pts,
  output logic [TB_W-1:0]   p2_tb_pts,
  output logic [SET_W-1:0]  p1_sets,
  output logic [SET_W-1:0]  p2_sets,
  output logic              tiebreak_active,
  output logic              p1_set_win,
  output logic              p2_set_win,
  output logic              p1_match_win,
  output logic              p2_match_win,
  output logic              protocol_err
);
  set_state_t state, state_nx;

  logic g_inc_a, g_inc_b, t_inc_a, t_inc_b;
  logic g_win_a, g_win_b, g_tie, t_win_a, t_win_b, t_tie_unused;
  logic set1, set2, match1, match2, err;
  logic g_clr, t_clr;

  // Simultaneous wins are a protocol error, so neither side is credited.
  assign g_inc_a = (state == S_GAMES)    && p1_game_win && !p2_game_win;
  assign g_inc_b = (state == S_GAMES)    && p2_game_win && !p1_game_win;
  assign t_inc_a = (state == S_TIEBREAK) && p1_point    && !p2_point;
  assign t_inc_b = (state == S_TIEBREAK) && p2_point    && !p1_point;

  always_comb begin
    state_nx = state;
    err      = 1'b0;
    case (state)
      S_GAMES:    err = p1_game_win & p2_game_win;
      S_TIEBREAK: err = p1_point & p2_point;
      default:    err = 1'b0;
    endcase
    set1   = g_win_a | t_win_a;
    set2   = g_win_b | t_win_b;
    match1 = set1 && (p1_sets == SET_W'(SETS_TO_WIN - 1));
    match2 = set2 && (p2_sets == SET_W'(SETS_TO_WIN - 1));
    if (set1 | set2)
      state_nx = (match1 | match2) ? S_MATCH_DONE : S_GAMES;
    else if (g_tie)
      state_nx = S_TIEBREAK;
    if (new_match)
      state_nx = S_GAMES;
  end

  assign g_clr = new_match | set1 | set2;
  assign t_clr = new_match | set1 | set2 | g_tie;

  tennis_race_counter #(.W(GAME_W), .TARGET(GAMES_PER_SET), .RENORM(1'b0)) u_games (
    .clk(clk), .rst_n(rst_n), .clr(g_clr), .inc_a(g_inc_a), .inc_b(g_inc_b),
    .cnt_a(p1_games), .cnt_b(p2_games), .win_a(g_win_a), .win_b(g_win_b),
    .tie_at_target(g_tie)
  );

  tennis_race_counter #(.W(TB_W), .TARGET(TB_POINTS), .RENORM(1'b1)) u_tb (
    .clk(clk), .rst_n(rst_n), .clr(t_clr), .inc_a(t_inc_a), .inc_b(t_inc_b),
    .cnt_a(p1_tb_pts), .cnt_b(p2_tb_pts), .win_a(t_win_a), .win_b(t_win_b),
    .tie_at_target(t_tie_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_GAMES;
      tiebreak_active <= 1'b0;
      p1_sets         <= '0;
      p2_sets         <= '0;
      p1_set_win      <= 1'b0;
      p2_set_win      <= 1'b0;
      p1_match_win    <= 1'b0;
      p2_match_win    <= 1'b0;
      protocol_err    <= 1'b0;
    end else begin
      state           <= state_nx;
      tiebreak_active <= (state_nx == S_TIEBREAK);
      p1_set_win      <= set1 & ~new_match;
      p2_set_win      <= set2 & ~new_match;
      protocol_err    <= err & ~new_match;
      if (new_match) begin
        p1_sets      <= '0;
        p2_sets      <= '0;
        p1_match_win <= 1'b0;
        p2_match_win <= 1'b0;
      end else begin
        if (set1)   p1_sets      <= p1_sets + SET_W'(1);
        if (set2)   p2_sets      <= p2_sets + SET_W'(1);
        if (match1) p1_match_win <= 1'b1;
        if (match2) p2_match_win <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tennis_set_match_scorer.sv
// Scoreboard bench: a behavioural score model pushes expected outputs per
// driven cycle; they are popped and compared just after the clock edge.
module tb_tennis_set_match_scorer;
  localparam int GPS = 6;
  localparam int TBP = 7;
  localparam int STW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic p1_game_win = 0, p2_game_win = 0, p1_point = 0, p2_point = 0, new_match = 0;
  logic [2:0] p1_games, p2_games;
  logic [3:0] p1_tb_pts, p2_tb_pts;
  logic [1:0] p1_sets, p2_sets;
  logic tiebreak_active, p1_set_win, p2_set_win, p1_match_win, p2_match_win, protocol_err;

  always #5 clk = ~clk;

  tennis_set_match_scorer dut (
    .clk(clk), .rst_n(rst_n),
    .p1_game_win(p1_game_win), .p2_game_win(p2_game_win),
    .p1_point(p1_point), .p2_point(p2_point), .new_match(new_match),
    .p1_games(p1_games), .p2_games(p2_games),
    .p1_tb_pts(p1_tb_pts), .p2_tb_pts(p2_tb_pts),
    .p1_sets(p1_sets), .p2_sets(p2_sets),
    .tiebreak_active(tiebreak_active),
    .p1_set_win(p1_set_win), .p2_set_win(p2_set_win),
    .p1_match_win(p1_match_win), .p2_match_win(p2_match_win),
    .protocol_err(protocol_err)
  );

  typedef struct packed {
    int g1, g2, t1, t2, s1, s2;
    logic tba, sw1, sw2, mw1, mw2, err;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0;

  // model state
  int mg1, mg2, mt1, mt2, ms1, ms2, mst;
  logic mmw1, mmw2, msw1, msw2, merr;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    mg1 = 0; mg2 = 0; mt1 = 0; mt2 = 0; ms1 = 0; ms2 = 0; mst = 0;
    mmw1 = 0; mmw2 = 0; msw1 = 0; msw2 = 0; merr = 0;
  endtask

  task automatic award(input int p);
    mg1 = 0; mg2 = 0; mt1 = 0; mt2 = 0; mst = 0;
    if (p == 1) begin
      ms1++; msw1 = 1;
      if (ms1 == STW) begin mmw1 = 1; mst = 2; end
    end else begin
      ms2++; msw2 = 1;
      if (ms2 == STW) begin mmw2 = 1; mst = 2; end
    end
  endtask

  task automatic model(input logic a, input logic b, input logic c, input logic d, input logic nm);
    msw1 = 0; msw2 = 0; merr = 0;
    if (nm) model_clear();
    else if (mst == 0) begin
      if (a && b) merr = 1;
      else if (a || b) begin
        if (a) mg1++; else mg2++;
        if (mg1 >= GPS && mg1 - mg2 >= 2) award(1);
        else if (mg2 >= GPS && mg2 - mg1 >= 2) award(2);
        else if (mg1 == GPS && mg2 == GPS) begin mst = 1; mt1 = 0; mt2 = 0; end
      end
    end else if (mst == 1) begin
      if (c && d) merr = 1;
      else if (c || d) begin
        if (c) mt1++; else mt2++;
        if (mt1 >= TBP && mt1 - mt2 >= 2) award(1);
        else if (mt2 >= TBP && mt2 - mt1 >= 2) award(2);
        else if (mt1 == mt2 && mt1 >= TBP - 1) begin mt1 = TBP - 1; mt2 = TBP - 1; end
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.g1 = mg1; e.g2 = mg2; e.t1 = mt1; e.t2 = mt2; e.s1 = ms1; e.s2 = ms2;
    e.tba = (mst == 1); e.sw1 = msw1; e.sw2 = msw2;
    e.mw1 = mmw1; e.mw2 = mmw2; e.err = merr;
    return e;
  endfunction

  task automatic compare_out(input string ph);
    exp_t e;
    if (sb.size() == 0) begin
      chk({ph, ".sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({ph, ".p1_games"}, int'(p1_games), e.g1);
    chk({ph, ".p2_games"}, int'(p2_games), e.g2);
    chk({ph, ".p1_tb"},    int'(p1_tb_pts), e.t1);
    chk({ph, ".p2_tb"},    int'(p2_tb_pts), e.t2);
    chk({ph, ".p1_sets"},  int'(p1_sets), e.s1);
    chk({ph, ".p2_sets"},  int'(p2_sets), e.s2);
    chk({ph, ".tb_act"},   int'(tiebreak_active), int'(e.tba));
    chk({ph, ".p1_sw"},    int'(p1_set_win), int'(e.sw1));
    chk({ph, ".p2_sw"},    int'(p2_set_win), int'(e.sw2));
    chk({ph, ".p1_mw"},    int'(p1_match_win), int'(e.mw1));
    chk({ph, ".p2_mw"},    int'(p2_match_win), int'(e.mw2));
    chk({ph, ".perr"},     int'(protocol_err), int'(e.err));
  endtask

  task automatic cyc(input string ph, input logic a, input logic b, input logic c,
                     input logic d, input logic nm);
    @(negedge clk);
    p1_game_win = a; p2_game_win = b; p1_point = c; p2_point = d; new_match = nm;
    model(a, b, c, d, nm);
    sb.push_back(snap());
    @(posedge clk);
    #1;
    compare_out(ph);
  endtask

  task automatic check_all_zero(input string ph);
    chk({ph, ".p1_games"}, int'(p1_games), 0);
    chk({ph, ".p2_games"}, int'(p2_games), 0);
    chk({ph, ".p1_tb"},    int'(p1_tb_pts), 0);
    chk({ph, ".p2_tb"},    int'(p2_tb_pts), 0);
    chk({ph, ".p1_sets"},  int'(p1_sets), 0);
    chk({ph, ".p2_sets"},  int'(p2_sets), 0);
    chk({ph, ".tb_act"},   int'(tiebreak_active), 0);
    chk({ph, ".sw"},       int'(p1_set_win | p2_set_win), 0);
    chk({ph, ".mw"},       int'(p1_match_win | p2_match_win), 0);
    chk({ph, ".perr"},     int'(protocol_err), 0);
  endtask

  task automatic to_tiebreak(input string ph);
    cyc(ph, 0, 0, 0, 0, 1);
    for (int i = 0; i < GPS; i++) begin
      cyc(ph, 1, 0, 0, 0, 0);
      cyc(ph, 0, 1, 0, 0, 0);
    end
  endtask

  initial begin
    model_clear();
    #12;
    check_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // straight 6-0 set for p1
    for (int i = 0; i < GPS; i++) cyc("set60", 1, 0, 0, 0, 0);
    cyc("set60_idle", 0, 0, 0, 0, 0);

    // 5-5, then p1, p2 -> 6-6 tiebreak; game wins ignored in tiebreak
    cyc("tb_entry", 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc("tb_entry", 1, 0, 0, 0, 0);
      cyc("tb_entry", 0, 1, 0, 0, 0);
    end
    cyc("g65", 1, 0, 0, 0, 0);
    cyc("g66", 0, 1, 0, 0, 0);
    cyc("tb_gw_ign", 0, 1, 0, 0, 0);
    cyc("tb_gw_ign", 1, 0, 0, 0, 0);

    // points to 6-6, then 7-6, 6-6 (renorm), 7-6, 8-6 win
    for (int i = 0; i < 6; i++) begin
      cyc("tb_pts", 0, 0, 1, 0, 0);
      cyc("tb_pts", 0, 0, 0, 1, 0);
    end
    cyc("tb_76", 0, 0, 1, 0, 0);
    cyc("tb_renorm", 0, 0, 0, 1, 0);
    cyc("tb_76b", 0, 0, 1, 0, 0);
    cyc("tb_win", 0, 0, 1, 0, 0);
    cyc("tb_after", 0, 0, 1, 0, 0);

    // simultaneous game wins at 3-2
    cyc("err_g", 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc("err_g", 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc("err_g", 0, 1, 0, 0, 0);
    cyc("err_g_both", 1, 1, 1, 1, 0);
    cyc("err_g_pts_only", 0, 0, 1, 1, 0);

    // simultaneous points in tiebreak
    to_tiebreak("err_t");
    cyc("err_t", 0, 0, 1, 0, 0);
    cyc("err_t_both", 0, 0, 1, 1, 0);
    cyc("err_t_gw_only", 1, 1, 0, 0, 0);

    // p2 takes two 6-0 sets; match done freezes everything
    cyc("match", 0, 0, 0, 0, 1);
    for (int i = 0; i < 2 * GPS; i++) cyc("match", 0, 1, 0, 0, 0);
    cyc("done_ign", 1, 0, 0, 0, 0);
    cyc("done_ign", 0, 1, 0, 0, 0);
    cyc("done_ign", 0, 0, 1, 0, 0);
    cyc("done_ign", 1, 1, 1, 1, 0);
    cyc("done_nm", 1, 0, 0, 0, 1);
    cyc("done_nm_idle", 0, 0, 0, 0, 0);

    // async reset mid-tiebreak at 5-4
    to_tiebreak("arst");
    for (int i = 0; i < 4; i++) begin
      cyc("arst", 0, 0, 1, 0, 0);
      cyc("arst", 0, 0, 0, 1, 0);
    end
    cyc("arst_54", 0, 0, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("arst_now");
    model_clear();
    @(negedge clk) rst_n = 1'b1;
    cyc("arst_games", 1, 0, 0, 0, 0);
    cyc("arst_pt_ign", 0, 0, 1, 0, 0);

    // random traffic against the model
    cyc("rand", 0, 0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic a, b, c, d, nm;
      a  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 2) == 0);
      c  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      nm = ($urandom_range(0, 99) == 0);
      cyc("rand", a, b, c, d, nm);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
